// File: rtl/double_tokens_pkg.sv
// Shared constants and helpers for the token doubler.
package double_tokens_pkg;
  localparam int DT_CNT_W_DEF  = 8;
  localparam int DT_STAT_W_DEF = 16;

  // Largest value representable in w bits, clamped to 32 bits.
  function automatic int unsigned sat_max(input int unsigned w);
    return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
  endfunction
endpackage

// File: rtl/double_tokens_if.sv
// Token stream bundle for double_tokens; statistics signals exist only with DOUBLE_TOKENS_STATS_EN.
interface double_tokens_if
`ifdef DOUBLE_TOKENS_STATS_EN
  #(parameter int STAT_W = double_tokens_pkg::DT_STAT_W_DEF)
`endif
  ;
  logic a;
  logic clr_ovf;
  logic b;
  logic busy;
  logic overflow;
`ifdef DOUBLE_TOKENS_STATS_EN
  logic [STAT_W-1:0] tokens_in;
  logic [STAT_W-1:0] tokens_out;
`endif

  modport master (
    output a, clr_ovf,
    input  b, busy, overflow
`ifdef DOUBLE_TOKENS_STATS_EN
    , input tokens_in, tokens_out
`endif
  );

  modport slave (
    input  a, clr_ovf,
    output b, busy, overflow
`ifdef DOUBLE_TOKENS_STATS_EN
    , output tokens_in, tokens_out
`endif
  );
endinterface

// File: rtl/double_tokens_sat_counter.sv
// Saturating up-counter: holds at all-ones, synchronous clear, async active-low reset.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)                    cnt_d = '0;
    else if (inc && cnt_q != '1) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign q = cnt_q;
endmodule

// File: rtl/double_tokens.sv
// Serial token expander: each '1' on a yields two '1's on b via a saturating pending counter.
// Optional statistics counters under DOUBLE_TOKENS_STATS_EN.
module double_tokens
  import double_tokens_pkg::*;
#(
  parameter int CNT_W = DT_CNT_W_DEF
`ifdef DOUBLE_TOKENS_STATS_EN
  , parameter int STAT_W = DT_STAT_W_DEF
`endif
) (
  input logic           clk,
  input logic           rst_n,
  double_tokens_if.slave tok
);
  // Two guard bits so pending + 2 never wraps before the saturation compare.
  localparam int             TW       = CNT_W + 2;
  localparam logic [TW-1:0]  PEND_MAX = TW'(sat_max(CNT_W));

  logic [CNT_W-1:0] pending_q, pending_d;
  logic             b_q, b_d;
  logic             ovf_q, ovf_d;
  logic [TW-1:0]    total, nxt;
  logic             sat;

  always_comb begin
    total     = TW'(pending_q) + (tok.a ? TW'(2) : TW'(0));
    b_d       = (total != '0);
    nxt       = b_d ? (total - TW'(1)) : '0;
    sat       = (nxt > PEND_MAX);
    pending_d = sat ? PEND_MAX[CNT_W-1:0] : nxt[CNT_W-1:0];
    // Saturation in the same cycle as a clear keeps the flag set.
    ovf_d     = sat | (ovf_q & ~tok.clr_ovf);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      b_q       <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      b_q       <= b_d;
      ovf_q     <= ovf_d;
    end
  end

  assign tok.b        = b_q;
  assign tok.busy     = (pending_q != '0);
  assign tok.overflow = ovf_q;

`ifdef DOUBLE_TOKENS_STATS_EN
  sat_counter #(.W(STAT_W)) u_tokens_in (
    .clk(clk), .rst_n(rst_n), .inc(tok.a), .clr(1'b0), .q(tok.tokens_in)
  );

  // b_d is the value b takes at this edge, so this counts every emitted '1'.
  sat_counter #(.W(STAT_W)) u_tokens_out (
    .clk(clk), .rst_n(rst_n), .inc(b_d), .clr(1'b0), .q(tok.tokens_out)
  );
`endif
endmodule

// File: tb/tb_double_tokens.sv
// Directed bench for double_tokens: default-width instance plus a CNT_W=3 instance for saturation.
module tb_double_tokens;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  double_tokens_if if_m ();
  double_tokens dut (.clk(clk), .rst_n(rst_n), .tok(if_m));

`ifdef DOUBLE_TOKENS_STATS_EN
  double_tokens_if #(.STAT_W(4)) if_s ();
  double_tokens #(.CNT_W(3), .STAT_W(4)) dut_s (.clk(clk), .rst_n(rst_n), .tok(if_s));
`else
  double_tokens_if if_s ();
  double_tokens #(.CNT_W(3)) dut_s (.clk(clk), .rst_n(rst_n), .tok(if_s));
`endif

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic a;
    logic clr;
    logic b;
    logic busy;
    logic ovf;
  } vec_t;

  function automatic vec_t mk(input logic a, input logic clr, input logic b,
                              input logic busy, input logic ovf);
    vec_t v;
    v.a = a; v.clr = clr; v.b = b; v.busy = busy; v.ovf = ovf;
    return v;
  endfunction

  vec_t tbl[18];

  initial begin
    int ones;

    // Expected outputs are the values right after the edge that samples a.
    // Single token: b high for two cycles, busy only while one token is pending.
    tbl[0]  = mk(1, 0, 1, 1, 0);
    tbl[1]  = mk(0, 0, 1, 0, 0);
    tbl[2]  = mk(0, 0, 0, 0, 0);
    tbl[3]  = mk(0, 0, 0, 0, 0);
    // a = 1100_1110_1000: pending 1,2,1,0,1,2,3,2,3,2,1,0 with b held high.
    tbl[4]  = mk(1, 0, 1, 1, 0);
    tbl[5]  = mk(1, 0, 1, 1, 0);
    tbl[6]  = mk(0, 0, 1, 1, 0);
    tbl[7]  = mk(0, 0, 1, 0, 0);
    tbl[8]  = mk(1, 0, 1, 1, 0);
    tbl[9]  = mk(1, 0, 1, 1, 0);
    tbl[10] = mk(1, 0, 1, 1, 0);
    tbl[11] = mk(0, 0, 1, 1, 0);
    tbl[12] = mk(1, 0, 1, 1, 0);
    tbl[13] = mk(0, 0, 1, 1, 0);
    tbl[14] = mk(0, 0, 1, 1, 0);
    tbl[15] = mk(0, 0, 1, 0, 0);
    tbl[16] = mk(0, 0, 0, 0, 0);
    tbl[17] = mk(0, 1, 0, 0, 0);

    if_m.a = 1'b0; if_m.clr_ovf = 1'b0;
    if_s.a = 1'b0; if_s.clr_ovf = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_b",    if_m.b, 0);
    chk("rst_busy", if_m.busy, 0);
    chk("rst_ovf",  if_m.overflow, 0);
    chk("rst_s_b",  if_s.b, 0);
`ifdef DOUBLE_TOKENS_STATS_EN
    chk("rst_tin",  if_m.tokens_in, 0);
    chk("rst_tout", if_m.tokens_out, 0);
`endif
    rst_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      if_m.a       = tbl[i].a;
      if_m.clr_ovf = tbl[i].clr;
      step();
      chk($sformatf("vec%0d_b", i),    if_m.b, tbl[i].b);
      chk($sformatf("vec%0d_busy", i), if_m.busy, tbl[i].busy);
      chk($sformatf("vec%0d_ovf", i),  if_m.overflow, tbl[i].ovf);
    end
    if_m.clr_ovf = 1'b0;

    // Saturation on CNT_W=3: the 8th consecutive token pushes next to 8.
    for (int k = 1; k <= 10; k++) begin
      if_s.a = 1'b1;
      step();
      chk($sformatf("sat%0d_b", k),   if_s.b, 1);
      chk($sformatf("sat%0d_ovf", k), if_s.overflow, (k >= 8) ? 1 : 0);
    end
    if_s.a = 1'b0;
    ones = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      ones += int'(if_s.b);
    end
    chk("sat_drain_ones", ones, 7);
    chk("sat_drain_busy", if_s.busy, 0);
    chk("sat_ovf_sticky", if_s.overflow, 1);

    if_s.clr_ovf = 1'b1;
    step();
    if_s.clr_ovf = 1'b0;
    chk("clr_ovf", if_s.overflow, 0);

    // Clear coinciding with a saturating cycle: set wins.
    for (int k = 0; k < 7; k++) begin
      if_s.a = 1'b1;
      step();
    end
    chk("pre_sat_ovf", if_s.overflow, 0);
    if_s.a = 1'b1; if_s.clr_ovf = 1'b1;
    step();
    if_s.a = 1'b0; if_s.clr_ovf = 1'b0;
    chk("clr_vs_sat_ovf", if_s.overflow, 1);
    repeat (10) step();

    // Reset mid-burst with pending=5; outputs drop with no clock edge.
    for (int k = 0; k < 5; k++) begin
      if_m.a = 1'b1;
      step();
    end
    if_m.a = 1'b0;
    chk("burst_busy", if_m.busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_b",    if_m.b, 0);
    chk("arst_busy", if_m.busy, 0);
    chk("arst_s_ovf", if_s.overflow, 0);
    #2 rst_n = 1'b1;
    if_m.a = 1'b1;
    step();
    if_m.a = 1'b0;
    ones = int'(if_m.b);
    for (int k = 0; k < 6; k++) begin
      step();
      ones += int'(if_m.b);
    end
    chk("post_rst_ones", ones, 2);
    chk("post_rst_busy", if_m.busy, 0);

`ifdef DOUBLE_TOKENS_STATS_EN
    #2 rst_n = 1'b0;
    #1;
    chk("stat_rst_tin", if_m.tokens_in, 0);
    chk("stat_rst_tout", if_s.tokens_out, 0);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if_m.a = 1'b1;
      if_s.a = (i < 9);
      step();
      if_m.a = 1'b0;
      if_s.a = 1'b0;
      repeat (3) step();
    end
    repeat (4) step();
    chk("stat_tin",    if_m.tokens_in, 20);
    chk("stat_tout",   if_m.tokens_out, 40);
    chk("stat_busy",   if_m.busy, 0);
    chk("stat_s_tin",  if_s.tokens_in, 9);
    chk("stat_s_tout", if_s.tokens_out, 15);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
